// File: rtl/pixel_binner_grid.sv
// Crops a 16-bit RGB byte stream and sums BIN x BIN pixel blocks into a GRID x GRID map,
// streaming each finished bin-row out over valid/ready. Define PXL_BINNER_SAT_EN for saturating sums.
module pixel_binner_grid #(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int CROP_L = 80,
  parameter int CROP_T = 0,
  parameter int BIN    = 15,
  parameter int GRID   = 32,
  parameter int ACC_W  = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     start_en,
  input  logic                     fmt_565,
  output logic                     get_data,
  input  logic [7:0]               p_data_sync,
  input  logic                     data_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ACC_W-1:0]         out_r,
  output logic [ACC_W-1:0]         out_g,
  output logic [ACC_W-1:0]         out_b,
  output logic [$clog2(GRID)-1:0]  out_col,
  output logic [$clog2(GRID)-1:0]  out_row,
  output logic                     out_last,
  output logic                     frame_done_o,
  output logic                     overrun_o,
  output logic                     pxl_idle_o
);

  localparam int IDX_W       = $clog2(GRID);
  localparam int CB_W        = (BIN > 1) ? $clog2(BIN) : 1;
  localparam int TOP_BYTES   = 2 * IMG_W * CROP_T;
  localparam int LEFT_BYTES  = 2 * CROP_L;
  localparam int BIN_BYTES   = 2 * GRID * BIN;
  localparam int RIGHT_BYTES = 2 * (IMG_W - CROP_L - GRID * BIN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(GRID - 1);
  localparam logic [CB_W-1:0]  LAST_CB  = CB_W'(BIN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SKIP_ROW, S_SKIP_L, S_BIN, S_SKIP_R, S_DONE
  } state_t;

  state_t state, next_state, row_start;

  logic [31:0]      byte_cnt, state_bytes;
  logic [CB_W-1:0]  col_in_bin, row_in_bin;
  logic [IDX_W-1:0] bin_col, bin_row, rd_col;
  logic             act, fmt, final_row;
  logic [7:0]       hi_byte;
  logic [5:0]       pix_r, pix_g, pix_b;
  logic             start_run, abort, take, last_byte, pix_done, swap, bin_final, accept;

  logic [ACC_W-1:0] acc_r [2][GRID];
  logic [ACC_W-1:0] acc_g [2][GRID];
  logic [ACC_W-1:0] acc_b [2][GRID];

  function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0] a, input logic [5:0] v);
`ifdef PXL_BINNER_SAT_EN
    logic [ACC_W:0] s;
    s = {1'b0, a} + (ACC_W + 1)'(v);
    acc_add = s[ACC_W] ? '1 : s[ACC_W-1:0];
`else
    acc_add = a + ACC_W'(v);
`endif
  endfunction

  assign get_data   = (state != S_IDLE) && (state != S_DONE);
  assign pxl_idle_o = (state == S_IDLE);
  assign start_run  = (state == S_IDLE) && start_en;
  assign abort      = (state != S_IDLE) && !start_en;
  assign take       = get_data && data_ready && !abort;
  assign row_start  = (LEFT_BYTES > 0) ? S_SKIP_L : S_BIN;
  assign bin_final  = (bin_row == LAST_IDX) && (row_in_bin == LAST_CB);
  assign pix_done   = take && (state == S_BIN) && byte_cnt[0];
  assign swap       = pix_done && last_byte && (row_in_bin == LAST_CB);
  assign accept     = out_valid && out_ready;

  always_comb begin
    state_bytes = 32'd0;
    case (state)
      S_SKIP_ROW: state_bytes = 32'(TOP_BYTES);
      S_SKIP_L:   state_bytes = 32'(LEFT_BYTES);
      S_BIN:      state_bytes = 32'(BIN_BYTES);
      S_SKIP_R:   state_bytes = 32'(RIGHT_BYTES);
      default:    state_bytes = 32'd0;
    endcase
    last_byte = take && (byte_cnt == state_bytes - 32'd1);
  end

  always_comb begin
    pix_b = {1'b0, p_data_sync[4:0]};
    if (fmt) begin
      pix_r = {1'b0, hi_byte[7:3]};
      pix_g = {hi_byte[2:0], p_data_sync[7:5]};
    end else begin
      pix_r = {1'b0, hi_byte[6:2]};
      pix_g = {1'b0, hi_byte[1:0], p_data_sync[7:5]};
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) state <= S_IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (abort) begin
      next_state = S_IDLE;
    end else begin
      case (state)
        S_IDLE:     if (start_en)  next_state = (CROP_T > 0) ? S_SKIP_ROW : row_start;
        S_SKIP_ROW: if (last_byte) next_state = row_start;
        S_SKIP_L:   if (last_byte) next_state = S_BIN;
        S_BIN:      if (last_byte) next_state = (RIGHT_BYTES > 0) ? S_SKIP_R :
                                                (bin_final ? S_DONE : row_start);
        S_SKIP_R:   if (last_byte) next_state = final_row ? S_DONE : row_start;
        S_DONE:     next_state = S_DONE;
        default:    next_state = S_IDLE;
      endcase
    end
  end

  // Byte/pixel/bin position tracking; the active bank flips when a bin-row completes.
  always_ff @(posedge clk) begin
    if (!resetn || start_run) begin
      byte_cnt   <= '0;
      col_in_bin <= '0;
      row_in_bin <= '0;
      bin_col    <= '0;
      bin_row    <= '0;
      hi_byte    <= '0;
      final_row  <= 1'b0;
      act        <= 1'b0;
      fmt        <= !resetn ? 1'b0 : fmt_565;
    end else if (take) begin
      byte_cnt <= last_byte ? '0 : byte_cnt + 32'd1;
      if (state == S_BIN) begin
        if (!byte_cnt[0]) begin
          hi_byte <= p_data_sync;
        end else if (last_byte) begin
          col_in_bin <= '0;
          bin_col    <= '0;
          final_row  <= bin_final;
          if (row_in_bin == LAST_CB) begin
            row_in_bin <= '0;
            bin_row    <= (bin_row == LAST_IDX) ? '0 : bin_row + 1'b1;
            act        <= ~act;
          end else begin
            row_in_bin <= row_in_bin + 1'b1;
          end
        end else if (col_in_bin == LAST_CB) begin
          col_in_bin <= '0;
          bin_col    <= bin_col + 1'b1;
        end else begin
          col_in_bin <= col_in_bin + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn || start_run) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < GRID; i++) begin
          acc_r[b][i] <= '0;
          acc_g[b][i] <= '0;
          acc_b[b][i] <= '0;
        end
      end
    end else begin
      if (pix_done) begin
        acc_r[act][bin_col] <= acc_add(acc_r[act][bin_col], pix_r);
        acc_g[act][bin_col] <= acc_add(acc_g[act][bin_col], pix_g);
        acc_b[act][bin_col] <= acc_add(acc_b[act][bin_col], pix_b);
      end
      if (swap) begin
        for (int i = 0; i < GRID; i++) begin
          acc_r[~act][i] <= '0;
          acc_g[~act][i] <= '0;
          acc_b[~act][i] <= '0;
        end
      end
    end
  end

  // A swap restarts readout; entries still pending at that moment are lost and flagged.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      out_valid    <= 1'b0;
      rd_col       <= '0;
      out_row      <= '0;
      overrun_o    <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      frame_done_o <= 1'b0;
      if (start_run) begin
        out_valid <= 1'b0;
        rd_col    <= '0;
        out_row   <= '0;
        overrun_o <= 1'b0;
      end else if (abort) begin
        out_valid <= 1'b0;
      end else begin
        if (accept && rd_col == LAST_IDX && out_row == LAST_IDX) frame_done_o <= 1'b1;
        if (swap) begin
          if (out_valid && !(out_ready && rd_col == LAST_IDX)) overrun_o <= 1'b1;
          out_valid <= 1'b1;
          rd_col    <= '0;
          out_row   <= bin_row;
        end else if (accept) begin
          if (rd_col == LAST_IDX) begin
            out_valid <= 1'b0;
            rd_col    <= '0;
          end else begin
            rd_col <= rd_col + 1'b1;
          end
        end
      end
    end
  end

  assign out_r    = acc_r[~act][rd_col];
  assign out_g    = acc_g[~act][rd_col];
  assign out_b    = acc_b[~act][rd_col];
  assign out_col  = rd_col;
  assign out_last = (rd_col == LAST_IDX);

endmodule

// File: tb/tb_pixel_binner_grid.sv
// Randomised frames on a small binner configuration, checked against a plain-arithmetic block-sum model.
module tb_pixel_binner_grid;

  localparam int IMG_W  = 12;
  localparam int IMG_H  = 10;
  localparam int CROP_L = 1;
  localparam int CROP_T = 1;
  localparam int BIN    = 3;
  localparam int GRID   = 3;
  localparam int ACC_W  = 8;
  localparam int IDX_W  = $clog2(GRID);
  localparam int MAXV   = (1 << ACC_W) - 1;
  localparam int FRAME_BYTES = 2 * IMG_W * IMG_H;

  logic clk = 1'b0;
  logic resetn, start_en, fmt_565, get_data, data_ready, out_valid, out_ready;
  logic [7:0] p_data_sync;
  logic [ACC_W-1:0] out_r, out_g, out_b;
  logic [IDX_W-1:0] out_col, out_row;
  logic out_last, frame_done_o, overrun_o, pxl_idle_o;

  int checks = 0;
  int errors = 0;
  int frame_px [IMG_H][IMG_W];
  bit cur_fmt;
  bit hold_ready = 1'b1;
  int ent = 0;
  int done_cnt = 0;

  pixel_binner_grid #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .CROP_L(CROP_L), .CROP_T(CROP_T),
    .BIN(BIN), .GRID(GRID), .ACC_W(ACC_W)
  ) dut (
    .clk(clk), .resetn(resetn), .start_en(start_en), .fmt_565(fmt_565),
    .get_data(get_data), .p_data_sync(p_data_sync), .data_ready(data_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_r(out_r), .out_g(out_g), .out_b(out_b),
    .out_col(out_col), .out_row(out_row), .out_last(out_last),
    .frame_done_o(frame_done_o), .overrun_o(overrun_o), .pxl_idle_o(pxl_idle_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Block sum over the cropped window, then wrap or clamp to the accumulator width.
  function automatic int exp_sum(input int br, input int bc, input int ch);
    int tot, px, v;
    tot = 0;
    for (int r = 0; r < BIN; r++) begin
      for (int c = 0; c < BIN; c++) begin
        px = frame_px[CROP_T + br * BIN + r][CROP_L + bc * BIN + c];
        if (ch == 2)      v = px & 31;
        else if (ch == 1) v = cur_fmt ? ((px >> 5) & 63) : ((px >> 5) & 31);
        else              v = cur_fmt ? ((px >> 11) & 31) : ((px >> 10) & 31);
        tot += v;
      end
    end
`ifdef PXL_BINNER_SAT_EN
    return (tot > MAXV) ? MAXV : tot;
`else
    return tot % (MAXV + 1);
`endif
  endfunction

  function automatic logic [7:0] frame_byte(input int k);
    int px;
    px = frame_px[k / (2 * IMG_W)][(k / 2) % IMG_W];
    return (k % 2 == 0) ? 8'((px >> 8) & 255) : 8'(px & 255);
  endfunction

  task automatic fill_pixels();
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        frame_px[r][c] = int'($urandom & 32'hFFFF);
  endtask

  // Feeds frame bytes in order; a byte advances only when the DUT consumes it.
  task automatic applyStimulus(input bit gaps, input int limit);
    int k, cyc, lim;
    bit consumed;
    k = 0;
    cyc = 0;
    lim = (limit < 0) ? FRAME_BYTES : limit;
    while (k < lim && cyc < 5000) begin
      @(negedge clk);
      p_data_sync = frame_byte(k);
      data_ready  = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      consumed    = get_data && data_ready;
      @(posedge clk);
      if (consumed) k++;
      cyc++;
    end
    if (k < lim) checkOutput("feed_timeout", k, lim);
    @(negedge clk);
    data_ready = 1'b0;
  endtask

  initial begin
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      out_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
      if (frame_done_o) done_cnt++;
      if (out_valid && out_ready) begin
        if (ent < GRID * GRID) begin
          checkOutput("out_row", int'(out_row), ent / GRID);
          checkOutput("out_col", int'(out_col), ent % GRID);
          checkOutput("out_last", int'(out_last), int'(ent % GRID == GRID - 1));
          checkOutput("out_r", int'(out_r), exp_sum(ent / GRID, ent % GRID, 0));
          checkOutput("out_g", int'(out_g), exp_sum(ent / GRID, ent % GRID, 1));
          checkOutput("out_b", int'(out_b), exp_sum(ent / GRID, ent % GRID, 2));
        end else begin
          checkOutput("extra_entry", ent, GRID * GRID - 1);
        end
        ent++;
      end
    end
  end

  task automatic run_frame(input bit fmt, input bit gaps, input bit new_pixels);
    int cyc;
    if (new_pixels) fill_pixels();
    ent = 0;
    done_cnt = 0;
    cur_fmt = fmt;
    hold_ready = 1'b0;
    @(negedge clk);
    fmt_565 = fmt;
    start_en = 1'b1;
    applyStimulus(gaps, -1);
    cyc = 0;
    while (ent < GRID * GRID && cyc < 500) begin
      @(posedge clk);
      cyc++;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("entries", ent, GRID * GRID);
    checkOutput("frame_done_pulses", done_cnt, 1);
    checkOutput("overrun_clean", int'(overrun_o), 0);
    checkOutput("done_get_data", int'(get_data), 0);
    checkOutput("done_not_idle", int'(pxl_idle_o), 0);
    start_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("idle_after_done", int'(pxl_idle_o), 1);
  endtask

  initial begin
    int cyc;
    resetn = 1'b0;
    start_en = 1'b0;
    fmt_565 = 1'b0;
    p_data_sync = 8'd0;
    data_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_idle", int'(pxl_idle_o), 1);
    checkOutput("rst_get_data", int'(get_data), 0);
    checkOutput("rst_valid", int'(out_valid), 0);
    checkOutput("rst_overrun", int'(overrun_o), 0);
    checkOutput("rst_done", int'(frame_done_o), 0);
    checkOutput("rst_out_r", int'(out_r), 0);
    resetn = 1'b1;

    run_frame(1'b0, 1'b1, 1'b1);
    run_frame(1'b1, 1'b1, 1'b1);

    // Abort mid-BIN, then replay the same pixels without gaps.
    fill_pixels();
    hold_ready = 1'b0;
    ent = 0;
    cur_fmt = 1'b1;
    @(negedge clk);
    fmt_565 = 1'b1;
    start_en = 1'b1;
    applyStimulus(1'b1, 2 * IMG_W * CROP_T + 2 * CROP_L + 10);
    start_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort_idle", int'(pxl_idle_o), 1);
    checkOutput("abort_get_data", int'(get_data), 0);
    checkOutput("abort_valid", int'(out_valid), 0);
    run_frame(1'b1, 1'b0, 1'b0);

    // Stalled readout: first bin-row held, then overwritten by the next swap.
    fill_pixels();
    hold_ready = 1'b1;
    cur_fmt = 1'b0;
    @(negedge clk);
    fmt_565 = 1'b0;
    start_en = 1'b1;
    fork
      applyStimulus(1'b1, -1);
      begin
        cyc = 0;
        while (!out_valid && cyc < 2000) begin
          @(negedge clk);
          cyc++;
        end
        checkOutput("ovr_first_valid", int'(out_valid), 1);
        repeat (10) @(negedge clk);
        checkOutput("ovr_hold_valid", int'(out_valid), 1);
        checkOutput("ovr_hold_col", int'(out_col), 0);
        checkOutput("ovr_hold_row", int'(out_row), 0);
        checkOutput("ovr_hold_r", int'(out_r), exp_sum(0, 0, 0));
        checkOutput("ovr_hold_b", int'(out_b), exp_sum(0, 0, 2));
        checkOutput("ovr_not_yet", int'(overrun_o), 0);
        cyc = 0;
        while (out_row == '0 && cyc < 2000) begin
          @(negedge clk);
          cyc++;
        end
        checkOutput("ovr_flag", int'(overrun_o), 1);
        checkOutput("ovr_row", int'(out_row), 1);
        checkOutput("ovr_col", int'(out_col), 0);
        checkOutput("ovr_new_g", int'(out_g), exp_sum(1, 0, 1));
      end
    join
    @(negedge clk);
    checkOutput("ovr_sticky_done", int'(overrun_o), 1);
    start_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("ovr_sticky_abort", int'(overrun_o), 1);
    start_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("ovr_cleared_run", int'(overrun_o), 0);
    start_en = 1'b0;
    @(posedge clk);

    // Reset while a bin-row is waiting in the readout bank.
    fill_pixels();
    @(negedge clk);
    start_en = 1'b1;
    applyStimulus(1'b1, 130);
    checkOutput("pre_reset_valid", int'(out_valid), 1);
    resetn = 1'b0;
    start_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("mid_rst_idle", int'(pxl_idle_o), 1);
    checkOutput("mid_rst_get_data", int'(get_data), 0);
    checkOutput("mid_rst_valid", int'(out_valid), 0);
    checkOutput("mid_rst_col", int'(out_col), 0);
    checkOutput("mid_rst_out_r", int'(out_r), 0);
    checkOutput("mid_rst_out_g", int'(out_g), 0);
    checkOutput("mid_rst_overrun", int'(overrun_o), 0);
    resetn = 1'b1;
    hold_ready = 1'b0;

    run_frame(1'b0, 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
